// File: rtl/ssd_pkg.sv
// ssd_pkg: shared types and constants for the seven-segment scan controller.
//   scan_state_t : scan FSM state encoding (BLANK guard cycle / SHOW dwell)
//   SEG_OFF      : all segments dark
//   SEG_LUT      : hex digit to {g,f,e,d,c,b,a} active-high segment pattern
package ssd_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Index 0 is hex digit 0; lower-case glyphs are used for b and d so they
  // are distinguishable from 8 and 0.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/ssd_seg_decode.sv
// ssd_seg_decode: purely combinational hex to seven-segment lookup.
//   hex_i [3:0] : hex digit to display
//   seg_o [6:0] : {g,f,e,d,c,b,a}, active-high
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_LUT[hex_i];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: multi-digit seven-segment scan controller.
// Holds NUM_DIGITS hex digits that are shifted in from the right by keypad
// entries, and time-multiplexes them onto one shared segment bus with a
// one-cycle blanking guard at every digit change.
//
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   key_val    : hex value of the pressed key
//   key_valid  : single-cycle pulse, key_val is valid this cycle
//   clear      : single-cycle pulse, zeroes all digits (beats key_valid)
//   hold       : level, suppresses key_valid (clear still acts)
//   seg        : registered segments {g,f,e,d,c,b,a}, active-high
//   digit_sel  : index of the digit currently driven
//   disp_vec   : digit register file, digit 0 in [3:0]
//   entry_cnt  : digits entered since clear, saturating at NUM_DIGITS
//   dbg_state  : current scan FSM state
//
// Input handshake: key_valid and clear are fire-and-forget strobes with no
// back-pressure; every cycle in which one is high is acted on in that same
// cycle, so back-to-back pulses are each accepted.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int CLK_FREQ   = 125_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int NUM_DIGITS = 2,
  parameter int LZ_BLANK   = 1,
  localparam int SEL_W     = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1,
  localparam int CNT_W     = $clog2(NUM_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              key_val,
  input  logic                    key_valid,
  input  logic                    clear,
  input  logic                    hold,
  output logic [6:0]              seg,
  output logic [SEL_W-1:0]        digit_sel,
  output logic [4*NUM_DIGITS-1:0] disp_vec,
  output logic [CNT_W-1:0]        entry_cnt,
  output scan_state_t             dbg_state
);

  localparam int DWELL = CLK_FREQ / SCAN_HZ;
  localparam int PW    = (DWELL > 2) ? $clog2(DWELL) : 1;

  if (DWELL < 2) begin : g_dwell_chk
    $error("ssd_scan_ctrl: DWELL = CLK_FREQ/SCAN_HZ must be at least 2");
  end
  if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_digits_chk
    $error("ssd_scan_ctrl: NUM_DIGITS must be in 2..8");
  end

  scan_state_t             state_q, state_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [6:0]              seg_q, seg_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic       dwell_end;
  logic [3:0] cur_hex;
  logic [6:0] cur_seg;
  logic       cur_blank;

  assign dwell_end = (presc_q == PW'(DWELL - 1));

  // ---------------------------------------------------------------------
  // Digit register file: clear wins over entry, hold only gates entry.
  // ---------------------------------------------------------------------
  always_comb begin
    disp_d = disp_q;
    cnt_d  = cnt_q;
    if (clear) begin
      disp_d = '0;
      cnt_d  = '0;
    end else if (key_valid && !hold) begin
      disp_d = {disp_q[4*NUM_DIGITS-5:0], key_val};
      if (cnt_q != CNT_W'(NUM_DIGITS)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Scan FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BLANK;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Scan FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      BLANK: state_d = SHOW;
      SHOW:  if (dwell_end) state_d = BLANK;
    endcase
  end

  // ---------------------------------------------------------------------
  // Scan FSM: outputs (prescaler, digit select, segment bus)
  // ---------------------------------------------------------------------
  // digit_sel only moves on the SHOW->BLANK edge, so whenever the next
  // state is SHOW, sel_q is already the digit that will be lit.
  assign cur_hex = disp_q[{sel_q, 2'b00} +: 4];

  ssd_seg_decode u_dec (
    .hex_i (cur_hex),
    .seg_o (cur_seg)
  );

  // Digit 0 is never blanked, so an empty display still shows one "0".
  assign cur_blank = (LZ_BLANK != 0) && (sel_q != '0) &&
                     (CNT_W'(sel_q) >= cnt_q);

  always_comb begin
    presc_d = '0;
    sel_d   = sel_q;
    seg_d   = SEG_OFF;
    if (state_q == SHOW) begin
      if (dwell_end) begin
        sel_d = (sel_q == SEL_W'(NUM_DIGITS - 1)) ? '0 : sel_q + SEL_W'(1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    // seg is loaded for the state being entered, so it is dark exactly
    // during BLANK and tracks the digit value every SHOW cycle.
    if (state_d == SHOW && !cur_blank) begin
      seg_d = cur_seg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      sel_q   <= '0;
      seg_q   <= SEG_OFF;
      disp_q  <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      disp_q  <= disp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign seg       = seg_q;
  assign digit_sel = sel_q;
  assign disp_vec  = disp_q;
  assign entry_cnt = cnt_q;
  assign dbg_state = state_q;

endmodule
